// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and backend handshake bundle for mem_port_arbiter.
// slave = arbiter side, master = pipeline/backend side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_done, m_rdata,
    output i_valid, i_rdata, i_stall, d_valid, d_rdata, d_stall,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_done, m_rdata,
    input  i_valid, i_rdata, i_stall, d_valid, d_rdata, d_stall,
           m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arb_perf_ctr.sv
// Free-running conflict and busy cycle counters, wrapping modulo 2^32.
module mem_arb_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        conflict,
  input  logic        busy,
  output logic [31:0] conflict_cnt,
  output logic [31:0] busy_cnt
);

  // Count qualifying cycles; both counters clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
      busy_cnt     <= '0;
    end else begin
      if (conflict) conflict_cnt <= conflict_cnt + 32'd1;
      if (busy)     busy_cnt     <= busy_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory backend between the
// IF stage (reads) and the MEM stage (reads/writes). One transaction in
// flight; data wins ties unless IF has lost STARVE_MAX times in a row.
// Optional feature macro: ARB_PERF_CNT_EN (conflict / busy cycle counters).
//
// state    | meaning
// ARB_IDLE | waiting for a request; arbitrate and load m_* on the way out
// ARB_BUSY | m_req high, m_* stable, waiting for m_done
// ARB_RESP | valid pulse to the granted requester, requests not sampled
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_busy_cnt
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state;
  arb_gnt_t            gnt;
  arb_gnt_t            pick;
  logic [STARVE_W-1:0] starve_cnt;

  // Data first, except when IF has been starved to the limit.
  always_comb begin
    pick = GNT_I;
    if (bus.d_req && !(bus.i_req && (starve_cnt == STARVE_LIM)))
      pick = GNT_D;
  end

  // Arbiter FSM with registered backend and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      gnt         <= GNT_I;
      starve_cnt  <= '0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= {ADDR_W{1'b0}};
      bus.m_wdata <= {DATA_W{1'b0}};
      bus.i_valid <= 1'b0;
      bus.i_rdata <= {DATA_W{1'b0}};
      bus.d_valid <= 1'b0;
      bus.d_rdata <= {DATA_W{1'b0}};
    end else begin
      bus.i_valid <= 1'b0;
      bus.d_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (bus.i_req || bus.d_req) begin
            gnt       <= pick;
            bus.m_req <= 1'b1;
            state     <= ARB_BUSY;
            if (pick == GNT_D) begin
              bus.m_we    <= bus.d_we;
              bus.m_addr  <= bus.d_addr;
              bus.m_wdata <= bus.d_wdata;
              if (bus.i_req && (starve_cnt != STARVE_LIM))
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              bus.m_we    <= 1'b0;
              bus.m_addr  <= bus.i_addr;
              bus.m_wdata <= {DATA_W{1'b0}};
              starve_cnt  <= '0;
            end
          end
        end
        ARB_BUSY: begin
          if (bus.m_done) begin
            bus.m_req <= 1'b0;
            state     <= ARB_RESP;
            if (gnt == GNT_D) begin
              bus.d_valid <= 1'b1;
              bus.d_rdata <= bus.m_we ? {DATA_W{1'b0}} : bus.m_rdata;
            end else begin
              bus.i_valid <= 1'b1;
              bus.i_rdata <= bus.m_rdata;
            end
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  // Stall whenever a request is pending without its response this cycle.
  assign bus.i_stall = bus.i_req & ~bus.i_valid;
  assign bus.d_stall = bus.d_req & ~bus.d_valid;

`ifdef ARB_PERF_CNT_EN
  logic conflict_cyc;

  // Both stages contending while the port is free.
  assign conflict_cyc = (state == ARB_IDLE) && bus.i_req && bus.d_req;

  mem_arb_perf_ctr u_perf (
    .clk          (clk),
    .rst          (rst),
    .conflict     (conflict_cyc),
    .busy         (bus.m_req),
    .conflict_cnt (perf_conflict_cnt),
    .busy_cnt     (perf_busy_cnt)
  );
`else
  assign perf_conflict_cnt = 32'd0;
  assign perf_busy_cnt     = 32'd0;
`endif

endmodule
